// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: handshake and data bundle between the ALU/control unit
// and the sequential divider.
//   master (control unit): drives start, signed_op, dividend, divisor;
//                          observes busy, done, quotient, remainder,
//                          div_by_zero.
//   slave  (divider)     : the mirror image.
`timescale 1ns/1ps
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle restoring divider for MIPS DIV/DIVU.
// One shift-subtract step per clock over WIDTH iterations. LO is the
// quotient, truncated toward zero. HI is the remainder, which takes the
// sign of the dividend.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset; aborts any operation
//   bus      - div_seq_ctrl_if slave:
//              start/signed_op/dividend/divisor are captured in IDLE;
//              busy stays high until done; done is a one-cycle pulse;
//              quotient/remainder/div_by_zero hold until the next
//              accepted start.
`timescale 1ns/1ps
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DZ   = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dvd_r, dvs_r, dmag_r;
  logic             sign_r, q_neg_r, r_neg_r;
  // The partial remainder never exceeds divisor-1, so its WIDTH+1'th bit
  // is always zero. Only the low WIDTH bits are stored. The trial
  // subtraction is still done at WIDTH+1 bits.
  logic [WIDTH-1:0] r_r, q_r;
  logic             pend_r, pend_dz_r;
  logic             busy_r, done_r, dz_r;
  logic [WIDTH-1:0] quo_r, rem_r;

  logic             accept_s, a_neg_s, b_neg_s, fits_s;
  logic [WIDTH:0]   shift_s, trial_s;

  // Two's-complement negation when neg is set; 0x80000000 maps to itself,
  // which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] cond_neg_f(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    if (neg) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Start acceptance, operand signs and the trial subtraction of one step
  always_comb begin
    accept_s = (state_r == S_IDLE) && bus.start && !pend_r;
    a_neg_s  = sign_r & dvd_r[WIDTH-1];
    b_neg_s  = sign_r & dvs_r[WIDTH-1];
    shift_s  = {r_r, q_r[WIDTH-1]};
    trial_s  = shift_s - {1'b0, dmag_r};
    fits_s   = ~trial_s[WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_PREP;
        else          state_nxt_s = S_IDLE;
      end
      S_PREP: begin
        if (dvs_r == WIDTH'(0)) state_nxt_s = S_DZ;
        else                    state_nxt_s = S_ITER;
      end
      S_ITER: begin
        if (cnt_r == CNT_W'(1)) state_nxt_s = S_FIX;
        else                    state_nxt_s = S_ITER;
      end
      S_FIX:   state_nxt_s = S_IDLE;
      S_DZ:    state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Operand capture, shift-subtract datapath and registered result/handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= CNT_W'(0);
      dvd_r     <= WIDTH'(0);
      dvs_r     <= WIDTH'(0);
      dmag_r    <= WIDTH'(0);
      sign_r    <= 1'b0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_r       <= WIDTH'(0);
      q_r       <= WIDTH'(0);
      pend_r    <= 1'b0;
      pend_dz_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
      quo_r     <= WIDTH'(0);
      rem_r     <= WIDTH'(0);
    end else begin
      done_r <= 1'b0;
      // Output register stage: the FSM is already back in IDLE, but busy
      // stays high and new starts are refused until results are published.
      if (pend_r) begin
        quo_r  <= q_r;
        rem_r  <= r_r;
        dz_r   <= pend_dz_r;
        done_r <= 1'b1;
        busy_r <= 1'b0;
        pend_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            dvd_r  <= bus.dividend;
            dvs_r  <= bus.divisor;
            sign_r <= bus.signed_op;
            busy_r <= 1'b1;
            dz_r   <= 1'b0;
          end
        end
        S_PREP: begin
          q_r     <= cond_neg_f(dvd_r, a_neg_s);
          dmag_r  <= cond_neg_f(dvs_r, b_neg_s);
          r_r     <= WIDTH'(0);
          q_neg_r <= a_neg_s ^ b_neg_s;
          r_neg_r <= a_neg_s;
          cnt_r   <= CNT_W'(WIDTH);
        end
        S_ITER: begin
          r_r   <= fits_s ? trial_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], fits_s};
          cnt_r <= cnt_r - CNT_W'(1);
        end
        S_FIX: begin
          q_r       <= cond_neg_f(q_r, q_neg_r);
          r_r       <= cond_neg_f(r_r, r_neg_r);
          pend_r    <= 1'b1;
          pend_dz_r <= 1'b0;
        end
        S_DZ: begin
          q_r       <= {WIDTH{1'b1}};
          r_r       <= dvd_r;
          pend_r    <= 1'b1;
          pend_dz_r <= 1'b1;
        end
        default: begin
          pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: self-checking bench for div_seq_ctrl. Expected results
// come from plain integer arithmetic on 64-bit values (SV / and % truncate
// toward zero, which matches MIPS DIV).
`timescale 1ns/1ps
module tb_div_seq_ctrl;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  div_seq_ctrl_if #(.WIDTH(32)) bus ();

  div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for DIV/DIVU, including the divide-by-zero convention.
  function automatic void ref_div(input logic sop, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (sop) begin
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Issue one operation (call #1 after a rising edge) and wait for done.
  // lat = edges after the sampling edge until done is seen, -1 on timeout.
  task automatic run_op(input logic sop, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic busy_ok);
    bus.start = 1'b1; bus.signed_op = sop; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // scramble the inputs: the divider must work from its captured copy
    bus.dividend = $urandom; bus.divisor = $urandom; bus.signed_op = ~sop;
    lat = 0; busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) lat = -1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.signed_op = 1'b0;
    bus.dividend = 32'd0; bus.divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/dz=%b%b%b required 000",
               bus.busy, bus.done, bus.div_by_zero);
    end
    n_tests++;
    if ({bus.quotient, bus.remainder} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: q=%h r=%h required 0/0", bus.quotient, bus.remainder);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic;
    int lat; logic bok;
    run_op(1'b0, 32'd100, 32'd7, lat, bok);
    n_tests++;
    if (lat != 35 || bok !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_latency: lat=%0d busy_ok=%b required 35/1", lat, bok);
    end
    n_tests++;
    if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0
        || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_100_7: q=%0d r=%0d dz=%b busy=%b required 14/2/0/0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.done !== 1'b0 || bus.quotient !== 32'd14) begin
      n_fail++;
      $display("FAIL done_pulse_hold: done=%b q=%0d required 0/14", bus.done, bus.quotient);
    end
  endtask

  task automatic test_signed_cases;
    logic [31:0] av [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bv [4] = '{32'd2, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF};
    logic        sv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] er [4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    int lat; logic bok;
    for (int i = 0; i < 4; i++) begin
      run_op(sv[i], av[i], bv[i], lat, bok);
      n_tests++;
      if (lat != 35 || bus.quotient !== eq[i] || bus.remainder !== er[i]
          || bus.div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL corner_%0d: lat=%0d q=%h r=%h dz=%b required 35/%h/%h/0",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int lat; logic bok;
    run_op(1'b0, 32'h1234, 32'd0, lat, bok);
    n_tests++;
    if (lat != 3 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'h1234
        || bus.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero: lat=%0d q=%h r=%h dz=%b required 3/ffffffff/1234/1",
               lat, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_tests++;
    if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL dz_clear: dz=%b busy=%b q=%h required 0/1/ffffffff",
               bus.div_by_zero, bus.busy, bus.quotient);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if (lat != 35 || bus.quotient !== 32'd10 || bus.remainder !== 32'd0
        || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL after_dz: lat=%0d q=%0d r=%0d dz=%b required 35/10/0/0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    int lat; int extra;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd5000; bus.divisor = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.signed_op = 1'b1;
        bus.dividend = 32'hFFFF_0000; bus.divisor = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    bus.start = 1'b0;
    n_tests++;
    if (lat != 35 || bus.quotient !== 32'd384 || bus.remainder !== 32'd8) begin
      n_fail++;
      $display("FAIL ignore_start: lat=%0d q=%0d r=%0d required 35/384/8",
               lat, bus.quotient, bus.remainder);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL no_queue: active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic bok;
    logic [31:0] eq, er; logic edz;
    run_op(1'b0, 32'd1000, 32'd9, lat, bok);
    n_tests++;
    if (lat != 35 || bus.quotient !== 32'd111 || bus.remainder !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required 35/111/1",
               lat, bus.quotient, bus.remainder);
    end
    // start in the done cycle
    bus.start = 1'b1; bus.signed_op = 1'b1;
    bus.dividend = 32'hFFFF_FC18; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 32'd111) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b q=%0d required 1/0/111",
               bus.busy, bus.done, bus.quotient);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    ref_div(1'b1, 32'hFFFF_FC18, 32'd7, eq, er, edz);
    n_tests++;
    if (lat != 35 || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d q=%h r=%h required 35/%h/%h",
               lat, bus.quotient, bus.remainder, eq, er);
    end
  endtask

  task automatic test_reset_midop;
    int lat; logic bok; int dones;
    run_op(1'b0, 32'd100, 32'd7, lat, bok);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd999; bus.divisor = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000
        || bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b done=%b dz=%b q=%h r=%h required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL aborted_op: active_cycles=%0d required 0", dones);
    end
    run_op(1'b0, 32'd999, 32'd4, lat, bok);
    n_tests++;
    if (lat != 35 || bok !== 1'b1 || bus.quotient !== 32'd249 || bus.remainder !== 32'd3) begin
      n_fail++;
      $display("FAIL after_reset: lat=%0d busy_ok=%b q=%0d r=%0d required 35/1/249/3",
               lat, bok, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_random;
    int lat; int exp_lat; logic bok;
    logic sop; logic [31:0] a, b, eq, er; logic edz; int sel;
    for (int i = 0; i < 60; i++) begin
      sop = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = $urandom_range(1, 300); end
        4:       b = a >> $urandom_range(1, 31);
        default: b = $urandom;
      endcase
      if (sel == 3 && $urandom_range(0, 1) == 1) b = -b;
      ref_div(sop, a, b, eq, er, edz);
      exp_lat = edz ? 3 : 35;
      run_op(sop, a, b, lat, bok);
      n_tests++;
      if (lat != exp_lat || bok !== 1'b1 || bus.quotient !== eq || bus.remainder !== er
          || bus.div_by_zero !== edz) begin
        n_fail++;
        $display("FAIL rand_%0d s=%b %h/%h: lat=%0d busy_ok=%b q=%h r=%h dz=%b required %0d/1/%h/%h/%b",
                 i, sop, a, b, lat, bok, bus.quotient, bus.remainder, bus.div_by_zero,
                 exp_lat, eq, er, edz);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset;
    test_divu_basic;
    test_signed_cases;
    test_div_by_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
